trdb_sample_capture: RTL
========================

Name: trdb_sample_capture

Overview:
Synthesizable, parametrised capture buffer for instruction-trace samples from the core's retire interface. It supports multiple retire channels per cycle and qualifies each sample by a run-time filter mode. Qualified samples are timestamped and stored in a circular buffer, then drained over a valid/ready stream toward the trace encoder or a DMA/debug reader. It replaces simulation-only sample dumping with hardware that works in silicon and FPGA and has overflow accounting.

Parameters:
NRET, 2, retire channels sampled per cycle (1..4, NRET <= DEPTH)
DEPTH, 16, buffer entries (power of two, >= 2)
XLEN, 32, width of address, instruction and tval
CAUSELEN, 5, exception cause width
PRIVLEN, 3, privilege-level width
TSLEN, 16, timestamp counter width
DROPW, 16, drop-counter width

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, synchronous and active-high
enable_i  input  1  capture enable; pops are unaffected
clear_i  input  1  flush buffer and zero the drop counter
mode_i  input  2  filter: 0=ALL, 1=VALID, 2=EXC, 3=reserved (treated as VALID)
wrap_i  input  1  full policy: 0=drop newest, 1=overwrite oldest
ivalid_i  input  NRET  per-channel retire valid
iexception_i  input  NRET  per-channel exception
interrupt_i  input  NRET  per-channel interrupt
cause_i  input  NRET x CAUSELEN  trap cause
tval_i  input  NRET x XLEN  trap value
priv_i  input  NRET x PRIVLEN  privilege level
iaddr_i  input  NRET x XLEN  instruction address
instr_i  input  NRET x XLEN  instruction word
compressed_i  input  NRET  compressed instruction flag
sample_o  output  trdb_sample_t  head-of-buffer sample
valid_o  output  1  buffer non-empty
ready_i  input  1  consumer accepts sample_o
count_o  output  clog2(DEPTH)+1  current fill level
drop_cnt_o  output  DROPW  saturating count of lost samples

Behaviour:
- Reset (rst_i high at clk_i edge): head, tail and count = 0. Timestamp = 0. drop_cnt_o = 0. Storage is zeroed, so sample_o = 0 and valid_o = 0.
- Timestamp: free-running TSLEN counter, +1 every cycle after reset, wraps to 0. It is not cleared by clear_i.
- Channel k qualifies when enable_i is high and:
  - ALL: always qualifies.
  - VALID: ivalid_i[k].
  - EXC: ivalid_i[k] & (iexception_i[k] | interrupt_i[k]).
- nq = number of qualifying channels this cycle.
- Record fields: timestamp, channel index, valid, exception, interrupt, cause, tval, priv, compressed, iaddr, instr.
- Qualifying channels are written in ascending channel order into consecutive slots starting at tail, modulo DEPTH. All records written in the same cycle carry the same timestamp.
- Push latency: a sample presented in cycle t is visible at sample_o/valid_o in cycle t+1 at the earliest.
- pop = valid_o & ready_i. sample_o comes directly from the head register, with zero read latency.
- free = DEPTH - count + pop. A same-cycle pop frees a slot for pushes in that cycle.
- If nq <= free: write all nq; count_next = count + nq - pop.
- If nq > free and wrap_i = 0: write the lowest-indexed `free` channels and discard the rest. drop_cnt += nq - free (saturating at all ones). count_next = DEPTH.
- If nq > free and wrap_i = 1: write all nq. head advances by pop + (nq - free). drop_cnt += nq - free (saturating). count_next = DEPTH.
- In overwrite mode, sample_o may change while valid_o & !ready_i. This is an intended stream-rule exception for this mode; in drop mode sample_o is stable until popped.
- clear_i has priority over push and pop. head, tail and count go to 0 and drop_cnt goes to 0. Samples presented that cycle are discarded and not counted. valid_o is 0 in the next cycle.
- Pointer wrap: head and tail are clog2(DEPTH)-bit and wrap naturally. count is one bit wider, so full (DEPTH) and empty (0) are distinct.
- Changing mode_i or wrap_i mid-stream takes effect in the same cycle. Buffer contents are kept.

Decomposition:
- Package trdb_pkg holds:
  - trdb_sample_t packed struct (field widths taken from package localparams matching the defaults).
  - trdb_mode_e enum {TRDB_ALL, TRDB_VALID, TRDB_EXC}.
  - TRDB_MAX_NRET constant.
- Sub-module trdb_capture_buffer: the multi-push/single-pop circular buffer with the drop/overwrite policy and the drop counter.
- The top level contains the timestamp counter, the per-channel qualifier, and compaction of qualifying channels into write lanes.

Test Plan:
- Reset then idle, mode=VALID, all ivalid=0 for 10 cycles -> valid_o=0, count_o=0, drop_cnt_o=0, sample_o=0.
- NRET=2, mode=VALID, ch0 iaddr=0x100 and ch1 iaddr=0x104, both valid in one cycle, ready_i=0 -> next cycle count_o=2. Pops return 0x100 (chan 0) then 0x104 (chan 1), both with the same timestamp.
- mode=EXC, ch1 iexception=1 with cause=5'h02, ch0 valid without trap -> only one entry stored: chan 1, cause 2.
- DEPTH=4, wrap=0, ready=0, push 3 cycles x 2 valid samples -> count_o=4, drop_cnt_o=2, head still holds the first sample.
- Same as above with wrap=1 -> count_o=4, drop_cnt_o=2, head holds the 3rd pushed sample; then with ready=1, a full buffer and 1 push in the same cycle -> no drop, count stays 4.
- count_o=3, then clear_i together with a 2-sample push and ready=1 -> next cycle count_o=0, valid_o=0, drop_cnt_o=0, timestamp still increments.

Source files
------------

// File: rtl/trdb_pkg.sv
// Shared types for the trace sample capture path: the stored record layout,
// filter modes and the qualification rule used per retire channel.
package trdb_pkg;

  localparam int TRDB_MAX_NRET = 4;
  localparam int TRDB_CHW      = 2;
  localparam int TRDB_XLEN     = 32;
  localparam int TRDB_CAUSELEN = 5;
  localparam int TRDB_PRIVLEN  = 3;
  localparam int TRDB_TSLEN    = 16;

  typedef enum logic [1:0] {
    TRDB_ALL   = 2'd0,
    TRDB_VALID = 2'd1,
    TRDB_EXC   = 2'd2
  } trdb_mode_e;

  typedef struct packed {
    logic [TRDB_TSLEN-1:0]    ts;
    logic [TRDB_CHW-1:0]      chan;
    logic                     valid;
    logic                     exception;
    logic                     interrupt;
    logic [TRDB_CAUSELEN-1:0] cause;
    logic [TRDB_XLEN-1:0]     tval;
    logic [TRDB_PRIVLEN-1:0]  priv;
    logic                     compressed;
    logic [TRDB_XLEN-1:0]     iaddr;
    logic [TRDB_XLEN-1:0]     instr;
  } trdb_sample_t;

  // Mode 3 is reserved and behaves like VALID.
  function automatic logic trdb_qualify(input logic [1:0] mode, input logic vld,
                                        input logic exc, input logic irq);
    case (mode)
      TRDB_ALL: return 1'b1;
      TRDB_EXC: return vld & (exc | irq);
      default:  return vld;
    endcase
  endfunction

endpackage

// File: rtl/trdb_capture_buffer.sv
// Multi-push / single-pop circular sample buffer with drop-newest or
// overwrite-oldest full policy and a saturating lost-sample counter.
module trdb_capture_buffer import trdb_pkg::*; #(
  parameter int NRET  = 2,
  parameter int DEPTH = 16,
  parameter int DROPW = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic                           wrap_i,
  input  trdb_sample_t [NRET-1:0]        push_data_i,
  input  logic [$clog2(DEPTH):0]         push_cnt_i,
  input  logic                           ready_i,
  output trdb_sample_t                   sample_o,
  output logic                           valid_o,
  output logic [$clog2(DEPTH):0]         count_o,
  output logic [DROPW-1:0]               drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trdb_sample_t   mem_q [DEPTH];
  logic [AW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic [DROPW-1:0] drop_q, drop_d;
  logic [CW-1:0]  free, nwr, ndrop;
  logic [DROPW:0] drop_sum;
  logic           pop;

  function automatic logic [DROPW-1:0] sat_drop(input logic [DROPW:0] sum);
    return sum[DROPW] ? {DROPW{1'b1}} : sum[DROPW-1:0];
  endfunction

  always_comb begin
    pop    = (count_q != '0) & ready_i;
    // A slot released by this cycle's pop is usable by this cycle's pushes.
    free   = CW'(DEPTH) - count_q + CW'(pop);
    head_d = head_q + AW'(pop);
    nwr    = push_cnt_i;
    ndrop  = '0;
    if (push_cnt_i <= free) begin
      count_d = count_q + push_cnt_i - CW'(pop);
    end else begin
      ndrop   = push_cnt_i - free;
      count_d = CW'(DEPTH);
      if (wrap_i) head_d = head_q + AW'(pop) + AW'(ndrop);
      else        nwr    = free;
    end
    tail_d   = tail_q + AW'(nwr);
    drop_sum = {1'b0, drop_q} + (DROPW+1)'(ndrop);
    drop_d   = sat_drop(drop_sum);
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      drop_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      if (!clear_i) begin
        for (int i = 0; i < NRET; i++) begin
          if (CW'(i) < nwr) mem_q[tail_q + AW'(i)] <= push_data_i[i];
        end
      end
    end
  end

  assign sample_o   = mem_q[head_q];
  assign valid_o    = (count_q != '0);
  assign count_o    = count_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: rtl/trdb_sample_capture.sv
// Retire-interface trace capture: timestamps, filters and compacts up to NRET
// samples per cycle into a circular buffer drained over valid/ready.
module trdb_sample_capture import trdb_pkg::*; #(
  parameter int NRET     = 2,
  parameter int DEPTH    = 16,
  parameter int XLEN     = 32,
  parameter int CAUSELEN = 5,
  parameter int PRIVLEN  = 3,
  parameter int TSLEN    = 16,
  parameter int DROPW    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       clear_i,
  input  logic [1:0]                 mode_i,
  input  logic                       wrap_i,
  input  logic [NRET-1:0]            ivalid_i,
  input  logic [NRET-1:0]            iexception_i,
  input  logic [NRET-1:0]            interrupt_i,
  input  logic [NRET*CAUSELEN-1:0]   cause_i,
  input  logic [NRET*XLEN-1:0]       tval_i,
  input  logic [NRET*PRIVLEN-1:0]    priv_i,
  input  logic [NRET*XLEN-1:0]       iaddr_i,
  input  logic [NRET*XLEN-1:0]       instr_i,
  input  logic [NRET-1:0]            compressed_i,
  output trdb_sample_t               sample_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [DROPW-1:0]           drop_cnt_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [TSLEN-1:0]       ts_q, ts_d;
  logic [NRET-1:0]        qual;
  trdb_sample_t           rec  [NRET];
  logic [CW-1:0]          pos  [NRET];
  logic [CW-1:0]          nq;
  trdb_sample_t [NRET-1:0] lane;

  assign ts_d = ts_q + TSLEN'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) ts_q <= '0;
    else       ts_q <= ts_d;
  end

  always_comb begin
    for (int k = 0; k < NRET; k++) begin
      qual[k]           = enable_i & trdb_qualify(mode_i, ivalid_i[k], iexception_i[k],
                                                  interrupt_i[k]);
      rec[k].ts         = TRDB_TSLEN'(ts_q);
      rec[k].chan       = TRDB_CHW'(k);
      rec[k].valid      = ivalid_i[k];
      rec[k].exception  = iexception_i[k];
      rec[k].interrupt  = interrupt_i[k];
      rec[k].cause      = TRDB_CAUSELEN'(cause_i[k*CAUSELEN +: CAUSELEN]);
      rec[k].tval       = TRDB_XLEN'(tval_i[k*XLEN +: XLEN]);
      rec[k].priv       = TRDB_PRIVLEN'(priv_i[k*PRIVLEN +: PRIVLEN]);
      rec[k].compressed = compressed_i[k];
      rec[k].iaddr      = TRDB_XLEN'(iaddr_i[k*XLEN +: XLEN]);
      rec[k].instr      = TRDB_XLEN'(instr_i[k*XLEN +: XLEN]);
    end
  end

  // Lane j carries the j-th qualifying channel in ascending channel order.
  always_comb begin
    nq = '0;
    for (int k = 0; k < NRET; k++) begin
      pos[k] = nq;
      nq     = nq + CW'(qual[k]);
    end
    lane = '0;
    for (int j = 0; j < NRET; j++) begin
      for (int k = 0; k < NRET; k++) begin
        if (qual[k] && pos[k] == CW'(j)) lane[j] = rec[k];
      end
    end
  end

  trdb_capture_buffer #(
    .NRET  (NRET),
    .DEPTH (DEPTH),
    .DROPW (DROPW)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .wrap_i      (wrap_i),
    .push_data_i (lane),
    .push_cnt_i  (nq),
    .ready_i     (ready_i),
    .sample_o    (sample_o),
    .valid_o     (valid_o),
    .count_o     (count_o),
    .drop_cnt_o  (drop_cnt_o)
  );

endmodule
